ftoi_sched: RTL and testbench
=============================

// Module: ftoi_sched
// PURPOSE
//  Round-robin scheduler that shares one fixed-latency ftoi converter among NUM_REQ requesters.
//  Accepts at most one float per cycle, registers it into the converter and tracks each op's
//  requester id through a tag pipeline. Returns the int result with the id and a range-error flag.
//  Sits between the issue logic and the ftoi unit in the FPU.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  LAT      2   ftoi cycles from unit_op valid to unit_result valid (>=1)
//  DATA_W   32  operand/result width (IEEE single in, two's-complement int out)
// PORTS
//  clk          in   1               single clock; all state on rising edge
//  reset        in   1               asynchronous, active-high reset
//  req_valid    in   NUM_REQ         requester i presents an op
//  req_op       in   NUM_REQ*DATA_W  packed operands, slice i = requester i
//  req_ready    out  NUM_REQ         one-hot grant, combinational from req_valid/state
//  hold         in   1               stop granting; in-flight ops still drain
//  drained      out  1               hold=1 and no op in flight
//  unit_op      out  DATA_W          registered operand to ftoi
//  unit_result  in   DATA_W          ftoi output, valid LAT cycles after unit_op
//  resp_valid   out  1               registered response strobe (no backpressure)
//  resp_id      out  $clog2(NUM_REQ) requester id of response
//  resp_data    out  DATA_W          converted int, truncated toward zero
//  resp_ovf     out  1               operand outside [-2^31, 2^31) or NaN/Inf; resp_data=0
// BEHAVIOUR
//  Reset: req_ready=0, unit_op=0, resp_valid=0, resp_id=0, resp_data=0, resp_ovf=0, drained=0,
//   rr pointer=NUM_REQ-1 (so requester 0 has top priority), tag pipeline all invalid.
//  Arbitration: when hold=0, grant the first requester with req_valid after the rr pointer,
//   wrapping; at most one req_ready per cycle. Transfer = req_valid[i]&req_ready[i] at edge.
//   On transfer the rr pointer moves to i; with no transfer it is unchanged.
//  Latency: transfer at edge t -> unit_op updated at t; unit_result sampled at edge t+LAT;
//   resp_* registered at edge t+LAT (visible cycle t+LAT), so LAT+1 edges end to end.
//   Back-to-back transfers give back-to-back responses in grant order.
//  Tag pipeline: LAT+1-deep shift register of {valid, id, ovf}; shifts every cycle.
//  ovf = (op[30:23] >= 8'd158) & ~(op == 32'hCF00_0000); computed at transfer.
//   When ovf, resp_data forced to 0 regardless of unit_result.
//  unit_op keeps the last transferred operand when idle (no toggling).
//  hold: asserted mid-stream blocks new grants from the next combinational evaluation;
//   drained rises in the first cycle with hold=1 and all tag valids clear. Deasserting hold
//   restores grants the same cycle; the rr pointer is preserved across hold.
//  Simultaneous: all requesters valid -> grants rotate 0,1,2,3,0...; a requester dropping
//   valid without transfer is legal and loses nothing.
//  Reset mid-operation clears all tags; in-flight results are discarded, never responded.
//  resp_valid is a pulse per op; no resp_ready. Consumers must always accept.
// STRUCTURE
//  fpu_pkg: typedef sched_tag_t {logic vld; logic [IDW-1:0] id; logic ovf;},
//   constant FTOI_OVF_EXP = 8'd158, constant INT_MIN_F = 32'hCF00_0000.
//  Sub-module rr_arbiter (NUM_REQ): req, enable, update -> one-hot grant, owns rr pointer.
//  Top: operand register, tag shift register, response register, drained logic.
// TESTING (LAT=2, model ftoi with behavioural $rtoi)
//  1 Req0 op 0x4060_0000 (3.5) -> resp cycle t+2: id=0, data=3, ovf=0.
//  2 Req2 op 0xC000_0000 (-2.0) and 0xBF80_0001 (-1.0000001) back-to-back
//    -> 0xFFFF_FFFE then 0xFFFF_FFFF, consecutive cycles, id=2.
//  3 All four valid continuously 8 cycles -> grants 0,1,2,3,0,1,2,3;
//    resp ids same order, one per cycle.
//  4 ops 0x4F00_0000 (2^31), 0x7FC0_0000 (NaN) -> ovf=1 data=0; 0xCF00_0000 -> 0x8000_0000 ovf=0.
//  5 Two ops in flight, assert hold -> no req_ready; both responses arrive; drained=1 the cycle after last.
//  6 Reset one cycle after a transfer -> no resp_valid ever for that op; req0 granted first after.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU scheduling types and float-to-int range constants.
package fpu_pkg;

    localparam int NUM_REQ_CFG = 4;
    localparam int IDW = $clog2(NUM_REQ_CFG);

    localparam logic [7:0]  FTOI_OVF_EXP = 8'd158;
    localparam logic [31:0] INT_MIN_F    = 32'hCF00_0000;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           ovf;
    } sched_tag_t;

    // -2^31 is the only float with exponent >= 158 that still fits an int32
    function automatic logic ftoi_ovf(input logic [31:0] op);
        return (op[30:23] >= FTOI_OVF_EXP) && (op != INT_MIN_F);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; pointer holds the last granted requester.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       enable,
    input  logic                       update,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int AW = $clog2(NUM_REQ);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic [AW-1:0] idx;
    logic          found;
    int            pos;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        pos      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = AW'(pos);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
        ptr_d = (update && found) ? grant_id : ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= AW'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ftoi_sched.sv
// Shares one fixed-latency ftoi unit among NUM_REQ requesters,
// tagging each op with its requester id and range-error flag.
module ftoi_sched #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 2,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_op,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       hold,
    output logic                       drained,
    output logic [DATA_W-1:0]          unit_op,
    input  logic [DATA_W-1:0]          unit_result,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [DATA_W-1:0]          resp_data,
    output logic                       resp_ovf
);
    import fpu_pkg::*;

    localparam int RIDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [RIDW-1:0]    grant_id;
    logic               xfer;
    logic [DATA_W-1:0]  op_sel;
    logic               any_vld;

    sched_tag_t        tag_q [0:LAT];
    sched_tag_t        tag_d [0:LAT];
    logic [DATA_W-1:0] unit_op_q;
    logic [DATA_W-1:0] unit_op_d;
    logic [DATA_W-1:0] resp_data_q;
    logic [DATA_W-1:0] resp_data_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .enable   (~hold & ~reset),
        .update   (xfer),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign op_sel    = req_op[int'(grant_id) * DATA_W +: DATA_W];

    always_comb begin
        unit_op_d = xfer ? op_sel : unit_op_q;
        tag_d[0]  = '0;
        if (xfer) begin
            tag_d[0].vld = 1'b1;
            tag_d[0].id  = IDW'(grant_id);
            tag_d[0].ovf = ftoi_ovf(op_sel);
        end
        for (int k = 1; k <= LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        // stage LAT-1 lines up with unit_result; stage LAT is the response
        resp_data_d = '0;
        if (tag_q[LAT-1].vld && !tag_q[LAT-1].ovf) begin
            resp_data_d = unit_result;
        end
        any_vld = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            any_vld = any_vld | tag_q[k].vld;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unit_op_q   <= '0;
            resp_data_q <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            unit_op_q   <= unit_op_d;
            resp_data_q <= resp_data_d;
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign unit_op    = unit_op_q;
    assign resp_valid = tag_q[LAT].vld;
    assign resp_id    = RIDW'(tag_q[LAT].id);
    assign resp_ovf   = tag_q[LAT].ovf;
    assign resp_data  = resp_data_q;
    assign drained    = hold & ~any_vld & ~reset;

endmodule

// File: tb/tb_ftoi_sched.sv
// Bench for ftoi_sched: behavioural ftoi unit, reference scheduler model, directed and random stimulus.
module tb_ftoi_sched;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int W   = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           hold = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_op = '0;
    logic [N-1:0]   req_ready;
    logic           drained;
    logic [W-1:0]   unit_op;
    logic [W-1:0]   unit_result;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_data;
    logic           resp_ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ftoi_sched #(
        .NUM_REQ (N),
        .LAT     (LAT),
        .DATA_W  (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_ready   (req_ready),
        .hold        (hold),
        .drained     (drained),
        .unit_op     (unit_op),
        .unit_result (unit_result),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_ovf    (resp_ovf)
    );

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic is_ovf(input logic [31:0] x);
        real r;
        if (x[30:23] == 8'hFF) return 1'b1;
        r = f2r(x);
        return (r >= 2147483648.0) || (r < -2147483648.0);
    endfunction

    function automatic logic [31:0] conv(input logic [31:0] x);
        if (is_ovf(x)) return 32'h0;
        return 32'($rtoi(f2r(x)));
    endfunction

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return {1'($urandom), 8'($urandom_range(100, 160)), 23'($urandom)};
    endfunction

    // ftoi unit: garbage on out-of-range so forcing to zero is observable
    logic [W-1:0] unit_s;
    always @(posedge clk) unit_s <= is_ovf(unit_op) ? 32'hDEAD_BEEF : conv(unit_op);
    assign unit_result = unit_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        int          id;
        logic [31:0] op;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          ptr = N - 1;
    logic        pend_vld = 1'b0;
    int          pend_id = 0;
    logic [31:0] pend_op = '0;
    logic [31:0] last_op = '0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic         infl;
        int           i;
        if (cyc > 0) begin
            if (reset) begin
                q.delete();
                ptr = N - 1;
                pend_vld = 1'b0;
                last_op = '0;
                chk("rst_ready", 32'(req_ready), 32'(0));
                chk("rst_resp_valid", 32'(resp_valid), 32'(0));
                chk("rst_drained", 32'(drained), 32'(0));
                chk("rst_unit_op", unit_op, 32'(0));
                chk("rst_resp", {resp_data[29:0], resp_id}, 32'(0));
            end else begin
                eg = '0;
                pend_vld = 1'b0;
                if (!hold) begin
                    for (int k = 1; k <= N; k++) begin
                        i = (ptr + k) % N;
                        if (!pend_vld && req_valid[i]) begin
                            pend_vld = 1'b1;
                            pend_id = i;
                            pend_op = req_op[i*W +: W];
                            eg[i] = 1'b1;
                        end
                    end
                end
                chk("grant", 32'(req_ready), 32'(eg));
                chk("unit_op", unit_op, last_op);
                infl = 1'b0;
                foreach (q[j]) if (q[j].due >= cyc) infl = 1'b1;
                chk("drained", 32'(drained), 32'(hold && !infl));
                if (q.size() > 0 && q[0].due == cyc) begin
                    chk("resp_valid", 32'(resp_valid), 32'(1));
                    chk("resp_id", 32'(resp_id), 32'(q[0].id));
                    chk("resp_ovf", 32'(resp_ovf), 32'(is_ovf(q[0].op)));
                    chk("resp_data", resp_data, conv(q[0].op));
                    void'(q.pop_front());
                end else begin
                    chk("resp_valid", 32'(resp_valid), 32'(0));
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (pend_vld && !reset) begin
            ptr = pend_id;
            last_op = pend_op;
            q.push_back('{cyc + LAT, pend_id, pend_op});
        end
        pend_vld = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] v);
        req_op[i*W +: W] = v;
    endtask

    task automatic expect_resp(input string name, input int lat_exp, input int id,
                               input logic [31:0] data, input logic ovf);
        int k;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            if (resp_valid) break;
            k++;
        end
        chk({name, "_lat"}, 32'(k), 32'(lat_exp));
        if (k < 8) begin
            chk({name, "_id"}, 32'(resp_id), 32'(id));
            chk({name, "_data"}, resp_data, data);
            chk({name, "_ovf"}, 32'(resp_ovf), 32'(ovf));
        end
    endtask

    initial begin
        int nresp;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        req_valid = 4'b0001;
        set_op(0, 32'h4060_0000);
        tick();
        req_valid = '0;
        expect_resp("t1", 2, 0, 32'd3, 1'b0);
        tick();

        req_valid = 4'b0100;
        set_op(2, 32'hC000_0000);
        tick();
        set_op(2, 32'hBF80_0001);
        tick();
        req_valid = '0;
        expect_resp("t2a", 1, 2, 32'hFFFF_FFFE, 1'b0);
        expect_resp("t2b", 0, 2, 32'hFFFF_FFFF, 1'b0);
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) set_op(i, rnd_op());
            @(negedge clk);
            chk("t3_grant", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        req_valid = 4'b0010;
        set_op(1, 32'h4F00_0000);
        tick();
        set_op(1, 32'h7FC0_0000);
        tick();
        set_op(1, 32'hCF00_0000);
        tick();
        req_valid = '0;
        expect_resp("t4a", 0, 1, 32'h0, 1'b1);
        expect_resp("t4b", 0, 1, 32'h0, 1'b1);
        expect_resp("t4c", 0, 1, 32'h8000_0000, 1'b0);
        repeat (2) tick();

        req_valid = 4'b0011;
        set_op(0, 32'h4120_0000);
        set_op(1, 32'hC120_0000);
        tick();
        tick();
        hold = 1'b1;
        @(negedge clk);
        chk("t5_no_grant", 32'(req_ready), 32'(0));
        expect_resp("t5a", 0, 0, 32'd10, 1'b0);
        expect_resp("t5b", 0, 1, 32'hFFFF_FFF6, 1'b0);
        chk("t5_drain_lo", 32'(drained), 32'(0));
        @(negedge clk);
        chk("t5_drained", 32'(drained), 32'(1));
        tick();
        hold = 1'b0;
        @(negedge clk);
        chk("t5_regrant", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        repeat (4) tick();

        req_valid = 4'b1000;
        set_op(3, 32'h4000_0000);
        tick();
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("t6_no_resp", 32'(nresp), 32'(0));
        tick();
        req_valid = '1;
        @(negedge clk);
        chk("t6_first_grant", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        tick();

        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_op(i, rnd_op());
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            tick();
        end
        req_valid = '0;
        hold = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
